// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and parity helper for the oversampling UART RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BRK   = 3'd5
    } rx_state_e;

    localparam int c_MAX_DATA_BITS = 9;

    // Expected parity bit for a payload; narrower payloads are zero-extended.
    function automatic logic calc_parity(input logic [c_MAX_DATA_BITS-1:0] data,
                                         input parity_e mode);
        logic w_x;
        w_x = ^data;
        case (mode)
            PAR_EVEN: return w_x;
            PAR_ODD:  return ~w_x;
            default:  return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : 2-FF synchroniser for rx plus 3-tap majority vote over ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx,
    output logic rx_sync,
    output logic rx_vote
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 2'b11;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            if (baud_tick) begin
                r_hist <= {r_hist[0], r_sync2};
            end
        end
    end

    assign rx_sync = r_sync2;

    // On a tick, this votes over the current and the two previous tick samples.
    assign rx_vote = (r_hist[1] & r_hist[0]) |
                     (r_hist[1] & r_sync2)   |
                     (r_hist[0] & r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ovs
// Description : Oversampling UART receiver with majority-vote sampling,
//               parity/framing/overrun reporting and valid/ready output.
//               Optional break detection: define UART_RX_BREAK_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_par_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 rx_break
`endif
);

    localparam int                 c_CNT_W     = $clog2(OVS);
    localparam int                 c_BIT_W     = $clog2(DATA_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_MID       = c_CNT_W'(OVS / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_END       = c_CNT_W'(OVS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam parity_e            c_PAR_MODE  = parity_e'(2'(PARITY));
    localparam rx_state_e          c_AFT_DATA  = (PARITY == 0) ? STOP : PAR;

    logic                 w_rx_sync;
    logic                 w_rx_vote;
    rx_state_e            r_state;
    rx_state_e            w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_done;
    logic                 w_done;
    logic                 w_mid;
    logic                 w_end;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 w_brk;
`endif

    uart_rx_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .rx_sync   (w_rx_sync),
        .rx_vote   (w_rx_vote)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // After START confirms mid-bit, every later decision lands one bit period on.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_mid       = (r_cnt == c_MID);
        w_end       = (r_cnt == c_END);
`ifdef UART_RX_BREAK_DETECT_EN
        w_brk       = 1'b0;
`endif
        if (baud_tick) begin
            case (r_state)
                IDLE:  if (!w_rx_sync) w_state_nxt = START;
                START: if (w_mid) w_state_nxt = w_rx_vote ? IDLE : DATA;
                DATA:  if (w_end && (r_bit_cnt == c_LAST_DATA)) w_state_nxt = c_AFT_DATA;
                PAR:   if (w_end) w_state_nxt = STOP;
                STOP: begin
                    if (w_end) begin
`ifdef UART_RX_BREAK_DETECT_EN
                        if ((r_bit_cnt == '0) && (r_shift == '0) && !w_rx_vote) begin
                            w_state_nxt = BRK;
                            w_brk       = 1'b1;
                        end else
`endif
                        if (r_bit_cnt == c_LAST_STOP) begin
                            w_state_nxt = IDLE;
                            w_done      = 1'b1;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK:   if (w_rx_vote) w_state_nxt = IDLE;
`endif
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else if (baud_tick) begin
            if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
                r_cnt     <= '0;
                r_bit_cnt <= '0;
            end else if (w_end) begin
                r_cnt     <= '0;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == START) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end
            if ((r_state == DATA) && w_end) begin
                r_shift <= {w_rx_vote, r_shift[DATA_BITS-1:1]};
            end
            if ((r_state == PAR) && w_end) begin
                r_par_err <= (w_rx_vote != calc_parity(c_MAX_DATA_BITS'(r_shift), c_PAR_MODE));
            end
            if ((r_state == STOP) && w_end && !w_rx_vote) begin
                r_frm_err <= 1'b1;
            end
        end
    end

    // Delivery happens one clk after the last stop decision so the flags are settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done       <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_par_err   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            r_done     <= w_done;
            rx_overrun <= 1'b0;
            if (r_done && (!rx_valid || rx_ready)) begin
                rx_data      <= r_shift;
                rx_par_err   <= r_par_err;
                rx_frame_err <= r_frm_err;
                rx_valid     <= 1'b1;
            end else begin
                if (r_done) begin
                    rx_overrun <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_break <= 1'b0;
        end else begin
            rx_break <= w_brk;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ovs
// Description : Directed self-checking bench for uart_rx_ovs (8N1, 7E1, 8N2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ovs;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       line;
    int         sel;
    logic [2:0] rx_ln;
    logic [2:0] ready;
    logic [2:0] valid;
    logic [2:0] par;
    logic [2:0] frm;
    logic [2:0] ovr;
    logic [2:0] valid_q;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [7:0] data_c;
    int         total;
    int         bad;
    int         n_ovr [3];
    int         n_vrise [3];
`ifdef UART_RX_BREAK_DETECT_EN
    logic [2:0] brk;
    int         n_brk [3];
`endif

    assign rx_ln[0] = (sel == 0) ? line : 1'b1;
    assign rx_ln[1] = (sel == 1) ? line : 1'b1;
    assign rx_ln[2] = (sel == 2) ? line : 1'b1;

    uart_rx_ovs u_dut_8n1 (
        .clk (clk), .rst (rst), .baud_tick (baud_tick), .rx (rx_ln[0]),
        .rx_data (data_a), .rx_valid (valid[0]), .rx_ready (ready[0]),
        .rx_par_err (par[0]), .rx_frame_err (frm[0]), .rx_overrun (ovr[0])
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break (brk[0])
`endif
    );

    uart_rx_ovs #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .OVS(16)) u_dut_7e1 (
        .clk (clk), .rst (rst), .baud_tick (baud_tick), .rx (rx_ln[1]),
        .rx_data (data_b), .rx_valid (valid[1]), .rx_ready (ready[1]),
        .rx_par_err (par[1]), .rx_frame_err (frm[1]), .rx_overrun (ovr[1])
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break (brk[1])
`endif
    );

    uart_rx_ovs #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVS(16)) u_dut_8n2 (
        .clk (clk), .rst (rst), .baud_tick (baud_tick), .rx (rx_ln[2]),
        .rx_data (data_c), .rx_valid (valid[2]), .rx_ready (ready[2]),
        .rx_par_err (par[2]), .rx_frame_err (frm[2]), .rx_overrun (ovr[2])
`ifdef UART_RX_BREAK_DETECT_EN
        , .rx_break (brk[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ovr[i]) n_ovr[i]++;
            if (valid[i] && !valid_q[i]) n_vrise[i]++;
`ifdef UART_RX_BREAK_DETECT_EN
            if (brk[i]) n_brk[i]++;
`endif
        end
        valid_q = valid;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // One baud tick every 4 clks; inputs change on the falling edge.
    task automatic tick();
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    // bits[0] is the start bit; one 16-tick cell per bit, optional 1-tick inversion.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gbit, input int goff);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < 16; k++) begin
                line = ((b == gbit) && (k == goff)) ? ~bits[b] : bits[b];
                tick();
            end
        end
        line = 1'b1;
    endtask

    task automatic accept(input int idx);
        ready[idx] = 1'b1;
        @(negedge clk);
        ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (valid !== 3'b000) begin bad++; $display("FAIL reset_valid: got %b want 000", valid); end
        total++; if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_a); end
        total++; if ((par | frm | ovr) !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", par | frm | ovr); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        sel = 0;
        send_bits({1'b1, 8'hA5, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if (valid[0] !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", valid[0]); end
        total++; if (data_a !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", data_a); end
        total++; if ({par[0], frm[0]} !== 2'b00) begin bad++; $display("FAIL basic_flags: got %b want 00", {par[0], frm[0]}); end
        idle(20);
        total++; if ({valid[0], data_a} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL basic_hold: got %b/%h want 1/a5", valid[0], data_a); end
        accept(0);
        total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL basic_drop: got %b want 0", valid[0]); end
    endtask

    task automatic test_parity();
        sel = 1;
        send_bits({1'b1, 1'b1, 7'h41, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if ({valid[1], data_b} !== {1'b1, 7'h41}) begin bad++; $display("FAIL par_bad_data: got %b/%h want 1/41", valid[1], data_b); end
        total++; if ({par[1], frm[1]} !== 2'b10) begin bad++; $display("FAIL par_bad_flags: got %b want 10", {par[1], frm[1]}); end
        accept(1);
        send_bits({1'b1, 1'b1, 7'h07, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if ({valid[1], data_b} !== {1'b1, 7'h07}) begin bad++; $display("FAIL par_ok_data: got %b/%h want 1/07", valid[1], data_b); end
        total++; if (par[1] !== 1'b0) begin bad++; $display("FAIL par_ok_flag: got %b want 0", par[1]); end
        accept(1);
    endtask

    task automatic test_start_abort();
        int v0;
        sel = 0;
        v0 = n_vrise[0];
        line = 1'b0;
        repeat (4) tick();
        idle(200);
        total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", valid[0]); end
        total++; if (n_vrise[0] !== v0) begin bad++; $display("FAIL abort_frames: got %0d want %0d", n_vrise[0], v0); end
    endtask

    task automatic test_glitch();
        sel = 0;
        send_bits({1'b1, 8'h3C, 1'b0}, 10, 3, 7);
        idle(2);
        total++; if ({valid[0], data_a} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL glitch_mid: got %b/%h want 1/3c", valid[0], data_a); end
        accept(0);
        send_bits({1'b1, 8'hC3, 1'b0}, 10, 1, 6);
        idle(2);
        total++; if ({valid[0], data_a} !== {1'b1, 8'hC3}) begin bad++; $display("FAIL glitch_early: got %b/%h want 1/c3", valid[0], data_a); end
        accept(0);
    endtask

    task automatic test_back_to_back();
        int o0;
        sel = 0;
        o0 = n_ovr[0];
        send_bits({1'b1, 8'h11, 1'b0}, 10, -1, 0);
        total++; if ({valid[0], data_a} !== {1'b1, 8'h11}) begin bad++; $display("FAIL b2b_first: got %b/%h want 1/11", valid[0], data_a); end
        send_bits({1'b1, 8'h22, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if (data_a !== 8'h11) begin bad++; $display("FAIL b2b_retain: got %h want 11", data_a); end
        total++; if (n_ovr[0] - o0 !== 1) begin bad++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr[0] - o0); end
        accept(0);
        send_bits({1'b1, 8'h33, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if ({valid[0], data_a} !== {1'b1, 8'h33}) begin bad++; $display("FAIL b2b_third: got %b/%h want 1/33", valid[0], data_a); end
        total++; if (n_ovr[0] - o0 !== 1) begin bad++; $display("FAIL b2b_overrun_once: got %0d want 1", n_ovr[0] - o0); end
        accept(0);
    endtask

    task automatic test_stop_bits();
        sel = 2;
        send_bits({1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1, 0);
        idle(2);
        total++; if ({valid[2], data_c} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL stop2_data: got %b/%h want 1/5a", valid[2], data_c); end
        total++; if (frm[2] !== 1'b1) begin bad++; $display("FAIL stop2_frame_err: got %b want 1", frm[2]); end
        accept(2);
        send_bits({1'b1, 1'b1, 8'hC3, 1'b0}, 11, -1, 0);
        idle(2);
        total++; if ({valid[2], data_c, frm[2]} !== {1'b1, 8'hC3, 1'b0}) begin bad++; $display("FAIL stop2_clean: got %b/%h/%b want 1/c3/0", valid[2], data_c, frm[2]); end
        accept(2);
    endtask

    task automatic test_break();
        int v0;
        sel = 0;
        v0 = n_vrise[0];
`ifdef UART_RX_BREAK_DETECT_EN
        begin
            int b0;
            b0 = n_brk[0];
            line = 1'b0;
            repeat (320) tick();
            idle(40);
            total++; if (n_brk[0] - b0 !== 1) begin bad++; $display("FAIL break_pulse: got %0d want 1", n_brk[0] - b0); end
            total++; if (n_vrise[0] !== v0) begin bad++; $display("FAIL break_no_valid: got %0d want %0d", n_vrise[0], v0); end
        end
`else
        line = 1'b0;
        repeat (320) tick();
        idle(200);
        total++; if ({valid[0], data_a} !== {1'b1, 8'h00}) begin bad++; $display("FAIL break_data: got %b/%h want 1/00", valid[0], data_a); end
        total++; if (frm[0] !== 1'b1) begin bad++; $display("FAIL break_frame_err: got %b want 1", frm[0]); end
        accept(0);
`endif
    endtask

    task automatic test_reset_mid();
        sel = 0;
        send_bits({1'b1, 8'h77, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if ({valid[0], data_a} !== {1'b1, 8'h77}) begin bad++; $display("FAIL rstmid_setup: got %b/%h want 1/77", valid[0], data_a); end
        send_bits({1'b1, 8'h96, 1'b0}, 4, -1, 0);
        line = 1'b0;
        rst = 1'b1;
        #1;
        total++; if ({valid[0], data_a} !== 9'h000) begin bad++; $display("FAIL rstmid_outputs: got %b/%h want 0/00", valid[0], data_a); end
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        send_bits({1'b1, 8'h96, 1'b0}, 10, -1, 0);
        idle(2);
        total++; if ({valid[0], data_a, frm[0]} !== {1'b1, 8'h96, 1'b0}) begin bad++; $display("FAIL rstmid_recover: got %b/%h/%b want 1/96/0", valid[0], data_a, frm[0]); end
        accept(0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        baud_tick = 1'b0;
        line      = 1'b1;
        sel       = 0;
        ready     = 3'b000;
        valid_q   = 3'b000;
        test_reset();
        test_basic();
        test_parity();
        test_start_abort();
        test_glitch();
        test_back_to_back();
        test_stop_bits();
        test_break();
        test_reset_mid();
        total++; if (n_ovr[1] + n_ovr[2] !== 0) begin bad++; $display("FAIL idle_overrun: got %0d want 0", n_ovr[1] + n_ovr[2]); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
